mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported synchronous RAM.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the data port always wins.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RD3} state_t;

  state_t                state, state_n;
  logic                  id_q, id_n;  // 1 = data port owns the transaction
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  if_ack_n, dm_ack_n, busy_n;
  logic                  mem_write_en_n, mem_read_en_n;
  logic [ADDR_WIDTH-1:0] mem_address_n;
  logic [DATA_WIDTH-1:0] mem_data_in_n, if_rdata_n, dm_rdata_n;
  logic                  if_elig, dm_elig, grant_dm;

  // A requester is masked during its own ack cycle so a held req is not re-served.
  assign if_elig = if_req & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_n;  // 1 = data port was granted last
  assign grant_dm = dm_elig & (~if_elig | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_n;
  end

  always_comb begin
    last_n = last_q;
    if (state == IDLE && (if_elig || dm_elig)) last_n = grant_dm;
  end
`else
  assign grant_dm = dm_elig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      id_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      busy         <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_address  <= '0;
      mem_data_in  <= '0;
    end else begin
      state        <= state_n;
      id_q         <= id_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      if_ack       <= if_ack_n;
      dm_ack       <= dm_ack_n;
      if_rdata     <= if_rdata_n;
      dm_rdata     <= dm_rdata_n;
      busy         <= busy_n;
      mem_write_en <= mem_write_en_n;
      mem_read_en  <= mem_read_en_n;
      mem_address  <= mem_address_n;
      mem_data_in  <= mem_data_in_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n    = state;
    id_n       = id_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    if_ack_n   = 1'b0;
    dm_ack_n   = 1'b0;
    if_rdata_n = if_rdata;
    dm_rdata_n = dm_rdata;
    case (state)
      IDLE: begin
        if (if_elig || dm_elig) begin
          id_n    = grant_dm;
          addr_n  = grant_dm ? dm_addr : if_addr;
          wdata_n = grant_dm ? dm_wdata : '0;
          state_n = (grant_dm && dm_we) ? WR : RD1;
        end
      end
      WR: begin
        state_n  = IDLE;
        dm_ack_n = id_q;
        if_ack_n = ~id_q;
      end
      RD1: state_n = RD2;
      RD2: state_n = RD3;
      RD3: begin
        state_n = IDLE;
        if (id_q) begin
          dm_rdata_n = mem_data_out;
          dm_ack_n   = 1'b1;
        end else begin
          if_rdata_n = mem_data_out;
          if_ack_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n         = (state_n != IDLE);
    mem_write_en_n = (state_n == WR);
    mem_read_en_n  = (state_n == RD1);
    mem_address_n  = busy_n ? addr_n : '0;
    mem_data_in_n  = (state_n == WR) ? wdata_n : '0;
  end

endmodule
